hd44780_lcd_ctrl: RTL and testbench
===================================

# hd44780_lcd_ctrl

Parametrised 4-bit-bus HD44780-class character LCD controller with 1–4 rows and configurable columns. It replaces the fixed 16x2 free-running sequencer with a valid/ready request port. It provides timed power-up initialisation, cursor tracking with automatic line wrap, and newline, clear and raw-command operations. It sits between display-formatting logic (SMPS status text) and the LCD pins.

## Interface
- CLK_HZ, 200000000, system clock frequency
- TICK_HZ, 40000, LCD tick rate; DIV = CLK_HZ/TICK_HZ clocks per tick (integer, ≥2)
- COLS, 16, visible columns per row (1..40)
- ROWS, 2, rows (1..4)
- PWRUP_TICKS, 800, power-up wait before first nibble (20 ms at defaults)
- EXEC_TICKS, 2, post-byte wait for ordinary commands/characters
- CLEAR_TICKS, 80, post-byte wait for commands 0x01/0x02
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_op  in  2  0=char, 1=newline, 2=clear, 3=raw command
- req_data  in  8  character code (op 0) or command byte (op 3); ignored otherwise
- req_ready  out  1  high when a request can be accepted
- bl_en  in  1  backlight request
- lcd_data  out  4  LCD DB7..DB4
- lcd_rs  out  1  0=command, 1=data
- lcd_en  out  1  LCD E strobe
- lcd_bl  out  1  backlight drive
- done  out  1  one-clk pulse when an accepted request completes
- cursor_row  out  2  current row
- cursor_col  out  8  current column (0..COLS)

## Operation
- Reset values: lcd_data=0, lcd_rs=0, lcd_en=0, lcd_bl=0, req_ready=0, done=0, cursor_row=0, cursor_col=0. State = PWRUP. Tick divider cleared.
- Divider: counts 0..DIV-1 and emits a one-clk tick at DIV-1. It is cleared on rst and on request acceptance. All state advances below occur on ticks only.
- Nibble write takes 3 ticks: SETUP (data/rs driven, en=0), STROBE (en=1), HOLD (en=0, data held). A byte is the high nibble then the low nibble (6 ticks), followed by a WAIT of EXEC_TICKS, or CLEAR_TICKS when the command byte is 0x01/0x02.
- States: PWRUP → INIT_NIB → INIT_BYTE → IDLE → {ADDR, BYTE} → WAIT → IDLE.
- INIT_NIB: nibble sequence 3, 3, 3, 2 (rs=0), each followed by a wait of EXEC_TICKS.
- INIT_BYTE: bytes 0x28 (or 0x20 when ROWS=1), 0x0C, 0x06, 0x01; the last uses the CLEAR wait. Then IDLE.
- IDLE: req_ready=1. Acceptance is the cycle where req_valid && req_ready; req_ready drops the next cycle. Requests are not accepted before init completes.
- op 0 char: if cursor_col==COLS, first issue ADDR = 0x80|offset(row') with row'=(row+1) mod ROWS and set col=0, row=row'. Then send req_data with rs=1 and increment col.
- op 1 newline: row=(row+1) mod ROWS, col=0, send 0x80|offset(row).
- op 2 clear: send 0x01 with the CLEAR wait; row=col=0.
- op 3 raw: send req_data with rs=0; cursor unchanged.
- Row offsets: row0 0x00, row1 0x40, row2 COLS, row3 0x40+COLS.
- Cursor outputs update on acceptance, and additionally on the wrap address step.
- done pulses on the clk after the final WAIT tick, then the block returns to IDLE.
- lcd_bl is registered bl_en, updated every clk independent of state. It is forced to 0 during rst.
- rst mid-operation: the next edge applies reset values (lcd_en low immediately) and init restarts from PWRUP.

## Timing
- Char/newline/raw latency: done asserts exactly (6+EXEC_TICKS)·DIV clks after acceptance; 8·DIV at defaults.
- Wrapping char: 2·(6+EXEC_TICKS)·DIV clks.
- Clear: (6+CLEAR_TICKS)·DIV clks.
- lcd_en pulse width is exactly DIV clks. Data/rs are stable for one tick before the rising edge of en and one tick after the falling edge of en.
- Throughput: req_ready re-asserts the cycle done pulses. Back-to-back accept is possible on that same cycle.

## Test plan
- Init (DIV=4, PWRUP_TICKS=10, CLEAR_TICKS=5): after rst release, no en pulse for 10 ticks. Then en-captured nibbles are 3,3,3,2,2,8,0,C,0,6,0,1 with rs=0. req_ready rises after the CLEAR wait.
- Char 0x41 at row0/col0: captured nibbles 4,1 with rs=1. done pulses at 8·DIV clks after acceptance. cursor_col=1.
- 17th char on 16x2: nibbles C,0 (rs=0) then the char nibbles (rs=1). Cursor ends at row1/col1. done at 16·DIV clks.
- Newline at row1 with ROWS=2: nibbles 8,0. Cursor ends at row0/col0. With ROWS=4 and COLS=20, newline from row1 sends 0x94.
- Clear then immediate char: clear done at (6+CLEAR_TICKS)·DIV. The char is accepted on the done cycle and its nibbles follow, writing at row0/col0.
- rst asserted during the STROBE of a char: lcd_en=0 on the next edge. All outputs take reset values. The init sequence repeats in full. bl_en toggling throughout is tracked on lcd_bl with 1-clk delay except while in rst.

Source files
------------

// File: rtl/hd44780_lcd_ctrl_if.sv
// rtl/hd44780_lcd_ctrl_if.sv - request/completion port of the HD44780 LCD controller
interface hd44780_lcd_ctrl_if;
  logic       req_valid;
  logic [1:0] req_op;
  logic [7:0] req_data;
  logic       req_ready;
  logic       done;

  modport master (output req_valid, req_op, req_data, input req_ready, done);
  modport slave  (input req_valid, req_op, req_data, output req_ready, done);
endinterface

// File: rtl/hd44780_lcd_ctrl.sv
// rtl/hd44780_lcd_ctrl.sv - 4-bit HD44780 LCD controller: timed init, cursor tracking with wrap,
// newline/clear/raw commands behind a valid/ready request port.
module hd44780_lcd_ctrl #(
  parameter int CLK_HZ      = 200000000,
  parameter int TICK_HZ     = 40000,
  parameter int COLS        = 16,
  parameter int ROWS        = 2,
  parameter int PWRUP_TICKS = 800,
  parameter int EXEC_TICKS  = 2,
  parameter int CLEAR_TICKS = 80
) (
  input  logic                 clk,
  input  logic                 rst,
  hd44780_lcd_ctrl_if.slave    req,
  input  logic                 bl_en,
  output logic [3:0]           lcd_data,
  output logic                 lcd_rs,
  output logic                 lcd_en,
  output logic                 lcd_bl,
  output logic [1:0]           cursor_row,
  output logic [7:0]           cursor_col
);

  localparam int          DIV      = CLK_HZ / TICK_HZ;
  localparam logic [31:0] DIV_M1   = 32'(DIV - 1);
  localparam logic [31:0] PWRUP_M1 = 32'(PWRUP_TICKS - 1);
  localparam logic [31:0] EXEC_M1  = 32'(EXEC_TICKS - 1);
  localparam logic [31:0] CLEAR_M1 = 32'(CLEAR_TICKS - 1);
  localparam logic [7:0]  COLS8    = 8'(COLS);
  localparam logic [1:0]  ROWS_M1  = 2'(ROWS - 1);

  typedef enum logic [2:0] {
    S_PWRUP, S_INIT_NIB, S_INIT_BYTE, S_IDLE, S_ADDR, S_BYTE, S_WAIT
  } state_t;

  state_t      state_q, state_d, ret_q, ret_d;
  logic [2:0]  ph_q, ph_d;
  logic [31:0] wcnt_q, wcnt_d, div_q, div_d;
  logic [7:0]  byte_q, byte_d, char_q, char_d, col_q, col_d;
  logic        rs_q, rs_d, pend_q, pend_d;
  logic [1:0]  idx_q, idx_d, row_q, row_d;
  logic [3:0]  data_q, data_d;
  logic        en_q, en_d, lrs_q, lrs_d, bl_q, ready_q, ready_d, done_q, done_d;

  logic        tick, accept, long_wait, l_go, l_rs;
  state_t      l_state;
  logic [7:0]  l_byte;
  logic [2:0]  last_ph, nxt_ph;
  logic [1:0]  row_next;

  function automatic logic [7:0] row_addr(input logic [1:0] r);
    case (r)
      2'd0: row_addr = 8'h80;
      2'd1: row_addr = 8'hC0;
      2'd2: row_addr = 8'h80 | COLS8;
      default: row_addr = 8'h80 | (8'h40 + COLS8);
    endcase
  endfunction

  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    case (i)
      2'd0: init_cmd = (ROWS == 1) ? 8'h20 : 8'h28;
      2'd1: init_cmd = 8'h0C;
      2'd2: init_cmd = 8'h06;
      default: init_cmd = 8'h01;
    endcase
  endfunction

  assign tick      = (div_q == DIV_M1);
  assign accept    = req.req_valid && ready_q;
  assign long_wait = !rs_q && (byte_q == 8'h01 || byte_q == 8'h02);
  assign last_ph   = (state_q == S_INIT_NIB) ? 3'd2 : 3'd5;
  assign nxt_ph    = ph_q + 3'd1;
  assign row_next  = (row_q == ROWS_M1) ? 2'd0 : row_q + 2'd1;

  always_comb begin
    state_d = state_q;  ret_d  = ret_q;   ph_d   = ph_q;   wcnt_d = wcnt_q;
    byte_d  = byte_q;   char_d = char_q;  col_d  = col_q;  row_d  = row_q;
    rs_d    = rs_q;     pend_d = pend_q;  idx_d  = idx_q;  data_d = data_q;
    en_d    = en_q;     lrs_d  = lrs_q;   ready_d = ready_q;
    done_d  = 1'b0;
    div_d   = (accept || tick) ? 32'd0 : div_q + 32'd1;
    l_go = 1'b0; l_state = S_BYTE; l_byte = 8'h00; l_rs = 1'b0;

    case (state_q)
      S_PWRUP: if (tick) begin
        if (wcnt_q == 32'd0) begin
          l_go = 1'b1; l_state = S_INIT_NIB; l_byte = 8'h30; idx_d = 2'd0;
        end else begin
          wcnt_d = wcnt_q - 32'd1;
        end
      end
      S_INIT_NIB, S_INIT_BYTE, S_ADDR, S_BYTE: if (tick) begin
        if (ph_q == last_ph) begin
          state_d = S_WAIT;
          ret_d   = state_q;
          wcnt_d  = long_wait ? CLEAR_M1 : EXEC_M1;
          en_d    = 1'b0;
        end else begin
          // phases 1 and 4 are the strobes; the nibble stays put through HOLD
          ph_d   = nxt_ph;
          en_d   = (nxt_ph == 3'd1) || (nxt_ph == 3'd4);
          data_d = (nxt_ph < 3'd3) ? byte_q[7:4] : byte_q[3:0];
        end
      end
      S_WAIT: if (tick) begin
        if (wcnt_q != 32'd0) begin
          wcnt_d = wcnt_q - 32'd1;
        end else begin
          case (ret_q)
            S_INIT_NIB: begin
              l_go = 1'b1;
              if (idx_q == 2'd3) begin
                l_state = S_INIT_BYTE; l_byte = init_cmd(2'd0); idx_d = 2'd0;
              end else begin
                l_state = S_INIT_NIB; l_byte = (idx_q == 2'd2) ? 8'h20 : 8'h30;
                idx_d = idx_q + 2'd1;
              end
            end
            S_INIT_BYTE: begin
              if (idx_q == 2'd3) begin
                state_d = S_IDLE; ready_d = 1'b1;
              end else begin
                l_go = 1'b1; l_state = S_INIT_BYTE; l_byte = init_cmd(idx_q + 2'd1);
                idx_d = idx_q + 2'd1;
              end
            end
            S_ADDR: begin
              if (pend_q) begin
                // wrap address is out; now the deferred character lands at col 0
                pend_d = 1'b0; col_d = 8'd1;
                l_go = 1'b1; l_state = S_BYTE; l_byte = char_q; l_rs = 1'b1;
              end else begin
                state_d = S_IDLE; ready_d = 1'b1; done_d = 1'b1;
              end
            end
            default: begin
              state_d = S_IDLE; ready_d = 1'b1; done_d = 1'b1;
            end
          endcase
        end
      end
      S_IDLE: if (accept) begin
        ready_d = 1'b0;
        l_go    = 1'b1;
        case (req.req_op)
          2'd0: begin
            if (col_q == COLS8) begin
              row_d = row_next; col_d = 8'd0; char_d = req.req_data; pend_d = 1'b1;
              l_state = S_ADDR; l_byte = row_addr(row_next);
            end else begin
              col_d = col_q + 8'd1; l_state = S_BYTE; l_byte = req.req_data; l_rs = 1'b1;
            end
          end
          2'd1: begin
            row_d = row_next; col_d = 8'd0; pend_d = 1'b0;
            l_state = S_ADDR; l_byte = row_addr(row_next);
          end
          2'd2: begin
            row_d = 2'd0; col_d = 8'd0; l_state = S_BYTE; l_byte = 8'h01;
          end
          default: begin
            l_state = S_BYTE; l_byte = req.req_data;
          end
        endcase
      end
      default: state_d = S_PWRUP;
    endcase

    if (l_go) begin
      state_d = l_state; byte_d = l_byte; rs_d = l_rs; ph_d = 3'd0;
      data_d  = l_byte[7:4]; lrs_d = l_rs; en_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_PWRUP;  ret_q  <= S_IDLE; ph_q   <= 3'd0;  wcnt_q <= PWRUP_M1;
      div_q   <= 32'd0;    byte_q <= 8'h00;  char_q <= 8'h00; col_q  <= 8'd0;
      row_q   <= 2'd0;     rs_q   <= 1'b0;   pend_q <= 1'b0;  idx_q  <= 2'd0;
      data_q  <= 4'h0;     en_q   <= 1'b0;   lrs_q  <= 1'b0;  bl_q   <= 1'b0;
      ready_q <= 1'b0;     done_q <= 1'b0;
    end else begin
      state_q <= state_d;  ret_q  <= ret_d;  ph_q   <= ph_d;   wcnt_q <= wcnt_d;
      div_q   <= div_d;    byte_q <= byte_d; char_q <= char_d; col_q  <= col_d;
      row_q   <= row_d;    rs_q   <= rs_d;   pend_q <= pend_d; idx_q  <= idx_d;
      data_q  <= data_d;   en_q   <= en_d;   lrs_q  <= lrs_d;  bl_q   <= bl_en;
      ready_q <= ready_d;  done_q <= done_d;
    end
  end

  assign req.req_ready = ready_q;
  assign req.done      = done_q;
  assign lcd_data      = data_q;
  assign lcd_rs        = lrs_q;
  assign lcd_en        = en_q;
  assign lcd_bl        = bl_q;
  assign cursor_row    = row_q;
  assign cursor_col    = col_q;

endmodule

// File: tb/tb_hd44780_lcd_ctrl.sv
// tb/tb_hd44780_lcd_ctrl.sv - directed bench for hd44780_lcd_ctrl (16x2 and 20x4, DIV=4)
module tb_hd44780_lcd_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic bl_en;
  logic [3:0] lcd_data1, lcd_data2;
  logic lcd_rs1, lcd_en1, lcd_bl1, lcd_rs2, lcd_en2, lcd_bl2;
  logic [1:0] row1, row2;
  logic [7:0] col1, col2;

  hd44780_lcd_ctrl_if if1();
  hd44780_lcd_ctrl_if if2();

  always #5 clk = ~clk;

  hd44780_lcd_ctrl #(.CLK_HZ(160000), .TICK_HZ(40000), .COLS(16), .ROWS(2),
                     .PWRUP_TICKS(10), .EXEC_TICKS(2), .CLEAR_TICKS(5)) dut1 (
    .clk(clk), .rst(rst), .req(if1.slave), .bl_en(bl_en),
    .lcd_data(lcd_data1), .lcd_rs(lcd_rs1), .lcd_en(lcd_en1), .lcd_bl(lcd_bl1),
    .cursor_row(row1), .cursor_col(col1));

  hd44780_lcd_ctrl #(.CLK_HZ(160000), .TICK_HZ(40000), .COLS(20), .ROWS(4),
                     .PWRUP_TICKS(10), .EXEC_TICKS(2), .CLEAR_TICKS(5)) dut2 (
    .clk(clk), .rst(rst), .req(if2.slave), .bl_en(bl_en),
    .lcd_data(lcd_data2), .lcd_rs(lcd_rs2), .lcd_en(lcd_en2), .lcd_bl(lcd_bl2),
    .cursor_row(row2), .cursor_col(col2));

  int n_vec = 0;
  int n_bad = 0;
  logic [4:0] cap1[$];
  logic [4:0] cap2[$];
  logic [4:0] exp_q[$];
  int en_run = 0, en_bad = 0, en_pulses = 0, bl_err = 0;
  logic bl_exp = 1'b0;
  logic bl_arm = 1'b0;
  int lat;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge lcd_en1) cap1.push_back({lcd_rs1, lcd_data1});
  always @(posedge lcd_en2) cap2.push_back({lcd_rs2, lcd_data2});

  always @(negedge clk) begin
    if (lcd_en1 === 1'b1) en_run++;
    else begin
      if (en_run != 0 && !rst) begin
        en_pulses++;
        if (en_run != 4) en_bad++;
      end
      en_run = 0;
    end
    if (bl_arm && lcd_bl1 !== bl_exp) bl_err++;
  end

  always @(posedge clk) bl_exp <= rst ? 1'b0 : bl_en;

  initial begin
    bl_en = 1'b1;
    repeat (6) @(negedge clk);
    forever begin
      repeat (7) @(negedge clk);
      bl_en = ~bl_en;
    end
  end

  function automatic logic rdy(input int which);
    return (which == 1) ? if1.req_ready : if2.req_ready;
  endfunction

  function automatic logic dn(input int which);
    return (which == 1) ? if1.done : if2.done;
  endfunction

  task automatic put_req(input int which, input logic [1:0] op, input logic [7:0] d);
    if (which == 1) begin if1.req_op = op; if1.req_data = d; if1.req_valid = 1'b1; end
    else begin if2.req_op = op; if2.req_data = d; if2.req_valid = 1'b1; end
  endtask

  task automatic wait_accept(input int which, input string tag);
    int n = 0;
    while (!rdy(which) && n < 2000) begin @(negedge clk); n++; end
    if (!rdy(which)) chk({tag, "_ready_timeout"}, 32'(rdy(which)), 32'd1);
    @(posedge clk);
    @(negedge clk);
    if (which == 1) if1.req_valid = 1'b0; else if2.req_valid = 1'b0;
  endtask

  task automatic wait_done(input int which, output int l);
    l = 0;
    do begin @(posedge clk); @(negedge clk); l++; end while (!dn(which) && l < 3000);
  endtask

  task automatic chk_nibs(input int which, input string tag);
    logic [4:0] got[$];
    got = (which == 1) ? cap1 : cap2;
    chk({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("%s_nib%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_data"},  32'(lcd_data1), 32'd0);
    chk({tag, "_rs"},    32'(lcd_rs1), 32'd0);
    chk({tag, "_en"},    32'(lcd_en1), 32'd0);
    chk({tag, "_bl"},    32'(lcd_bl1), 32'd0);
    chk({tag, "_ready"}, 32'(if1.req_ready), 32'd0);
    chk({tag, "_done"},  32'(if1.done), 32'd0);
    chk({tag, "_row"},   32'(row1), 32'd0);
    chk({tag, "_col"},   32'(col1), 32'd0);
  endtask

  // rst is released by the caller at a falling edge just before this runs
  task automatic wait_init(input string tag);
    int n = 0;
    int en_at = 0;
    while (n < 400 && !if1.req_ready) begin
      @(posedge clk); @(negedge clk); n++;
      if (lcd_en1 && en_at == 0) en_at = n;
    end
    chk({tag, "_first_en"}, 32'(en_at), 32'd44);
    chk({tag, "_ready_at"}, 32'(n), 32'd260);
    chk({tag, "_ready2"},   32'(if2.req_ready), 32'd1);
    exp_q = {5'h03, 5'h03, 5'h03, 5'h02, 5'h02, 5'h08, 5'h00, 5'h0C, 5'h00, 5'h06, 5'h00, 5'h01};
    chk_nibs(1, tag);
  endtask

  initial begin
    rst = 1'b1;
    if1.req_valid = 1'b0; if1.req_op = 2'd0; if1.req_data = 8'h00;
    if2.req_valid = 1'b0; if2.req_op = 2'd0; if2.req_data = 8'h00;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    bl_arm = 1'b1;
    cap1.delete(); cap2.delete();
    rst = 1'b0;
    wait_init("init");

    cap1.delete();
    put_req(1, 2'd0, 8'h41); wait_accept(1, "charA"); wait_done(1, lat);
    chk("charA_lat", 32'(lat), 32'd32);
    exp_q = {5'h14, 5'h11}; chk_nibs(1, "charA");
    chk("charA_col", 32'(col1), 32'd1);
    chk("charA_row", 32'(row1), 32'd0);

    for (int i = 0; i < 15; i++) begin
      put_req(1, 2'd0, 8'(8'h42 + i)); wait_accept(1, "fill"); wait_done(1, lat);
    end
    chk("fill_col", 32'(col1), 32'd16);
    chk("fill_row", 32'(row1), 32'd0);

    cap1.delete();
    put_req(1, 2'd0, 8'h5A); wait_accept(1, "wrap"); wait_done(1, lat);
    chk("wrap_lat", 32'(lat), 32'd64);
    exp_q = {5'h0C, 5'h00, 5'h15, 5'h1A}; chk_nibs(1, "wrap");
    chk("wrap_row", 32'(row1), 32'd1);
    chk("wrap_col", 32'(col1), 32'd1);

    cap1.delete();
    put_req(1, 2'd1, 8'h00); wait_accept(1, "nl"); wait_done(1, lat);
    chk("nl_lat", 32'(lat), 32'd32);
    exp_q = {5'h08, 5'h00}; chk_nibs(1, "nl");
    chk("nl_row", 32'(row1), 32'd0);
    chk("nl_col", 32'(col1), 32'd0);

    cap2.delete();
    put_req(2, 2'd1, 8'h00); wait_accept(2, "nl4a"); wait_done(2, lat);
    exp_q = {5'h0C, 5'h00}; chk_nibs(2, "nl4a");
    chk("nl4a_row", 32'(row2), 32'd1);
    cap2.delete();
    put_req(2, 2'd1, 8'h00); wait_accept(2, "nl4b"); wait_done(2, lat);
    chk("nl4b_lat", 32'(lat), 32'd32);
    exp_q = {5'h09, 5'h04}; chk_nibs(2, "nl4b");
    chk("nl4b_row", 32'(row2), 32'd2);
    chk("nl4b_col", 32'(col2), 32'd0);

    put_req(1, 2'd0, 8'h42); wait_accept(1, "pre"); wait_done(1, lat);
    cap1.delete();
    put_req(1, 2'd2, 8'h00); wait_accept(1, "clr");
    chk("clr_col_acc", 32'(col1), 32'd0);
    put_req(1, 2'd0, 8'h30);
    wait_done(1, lat);
    chk("clr_lat", 32'(lat), 32'd44);
    chk("clr_ready_on_done", 32'(if1.req_ready), 32'd1);
    wait_accept(1, "b2b");
    chk("b2b_ready_low", 32'(if1.req_ready), 32'd0);
    chk("b2b_setup_data", 32'(lcd_data1), 32'h3);
    chk("b2b_setup_rs", 32'(lcd_rs1), 32'd1);
    wait_done(1, lat);
    chk("b2b_lat", 32'(lat), 32'd32);
    exp_q = {5'h00, 5'h01, 5'h13, 5'h10}; chk_nibs(1, "b2b");
    chk("b2b_row", 32'(row1), 32'd0);
    chk("b2b_col", 32'(col1), 32'd1);

    cap1.delete();
    put_req(1, 2'd3, 8'h0E); wait_accept(1, "raw"); wait_done(1, lat);
    chk("raw_lat", 32'(lat), 32'd32);
    exp_q = {5'h00, 5'h0E}; chk_nibs(1, "raw");
    chk("raw_col", 32'(col1), 32'd1);
    put_req(1, 2'd3, 8'h02); wait_accept(1, "home"); wait_done(1, lat);
    chk("home_lat", 32'(lat), 32'd44);

    put_req(1, 2'd0, 8'h41); wait_accept(1, "mid");
    begin
      int n = 0;
      while (!lcd_en1 && n < 50) begin @(negedge clk); n++; end
      chk("mid_strobe_seen", 32'(lcd_en1), 32'd1);
    end
    rst = 1'b1;
    @(negedge clk);
    chk_reset("midrst");
    @(negedge clk);
    cap1.delete(); cap2.delete();
    rst = 1'b0;
    wait_init("reinit");

    chk("en_width", 32'(en_bad), 32'd0);
    chk("en_pulses_seen", 32'(en_pulses > 50), 32'd1);
    chk("bl_track", 32'(bl_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
